cabac_bit_feeder: RTL and testbench

- Upstream refill stage for the CABAC arithmetic decoder.
- Buffers the incoming bitstream bytes (valid/ready) in a 32-bit MSB-aligned bit buffer.
- Each cycle, supplies the decoder with the fresh bits it needs:
  - Regular path: ORs num_bits new bits into the decoder's renormalised value.
  - Bypass path: presents up to 4 bypass bits.
- Consumes exactly the bits the decoder used, and tracks consumed-bit count and underrun.

---
 rtl/cabac_pkg.sv | 9 +
 rtl/cabac_bit_shifter.sv | 36 +++
 rtl/cabac_bit_feeder.sv | 86 ++++++++
 tb/tb_cabac_bit_feeder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cabac_pkg.sv
// Shared constants for the CABAC bitstream refill path.
package cabac_pkg;

  localparam int BUF_WIDTH_DEF = 32;
  localparam int BYTE_BITS     = 8;
  localparam int MAX_RE_SHIFT  = 7;
  localparam int MAX_EP_BINS   = 4;

endpackage

// File: rtl/cabac_bit_shifter.sv
// Combinational next-state for the MSB-aligned bit buffer: drop the consumed
// bits from the top, then drop an accepted byte in directly below the bits
// that remain.
module cabac_bit_shifter
  import cabac_pkg::*;
#(
  parameter int BUF_WIDTH = BUF_WIDTH_DEF,
  parameter int AW        = $clog2(BUF_WIDTH + 1)
) (
  input  logic [BUF_WIDTH-1:0] bit_buf,
  input  logic [AW-1:0]        cnt,
  input  logic [2:0]           need,
  input  logic [7:0]           byte_in,
  input  logic                 accept,
  output logic [BUF_WIDTH-1:0] buf_next,
  output logic [AW-1:0]        cnt_next
);

  logic [AW-1:0]        need_w;
  logic [AW-1:0]        taken;
  logic [AW-1:0]        rem;
  logic [BUF_WIDTH-1:0] shifted;
  logic [BUF_WIDTH-1:0] inserted;

  // Bits below cnt are always zero, so the byte can be ORed into place.
  always_comb begin
    need_w   = AW'(need);
    taken    = (need_w > cnt) ? cnt : need_w;
    rem      = cnt - taken;
    shifted  = bit_buf << need;
    inserted = {byte_in, {(BUF_WIDTH-BYTE_BITS){1'b0}}} >> rem;
    buf_next = accept ? (shifted | inserted) : shifted;
    cnt_next = rem + (accept ? AW'(BYTE_BITS) : '0);
  end

endmodule

// File: rtl/cabac_bit_feeder.sv
// Bit buffer feeding the CABAC arithmetic decoder: accepts stream bytes,
// supplies renormalisation and bypass bits, and tracks consumption/underrun.
module cabac_bit_feeder
  import cabac_pkg::*;
#(
  parameter int  BUF_WIDTH = BUF_WIDTH_DEF,
  parameter int  CNT_WIDTH = 32,
  localparam int AW        = $clog2(BUF_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic                 eos,
  input  logic                 cons_valid,
  output logic                 cons_ready,
  input  logic                 bypass,
  input  logic [2:0]           num_bits,
  input  logic [1:0]           n_bin,
  input  logic [15:0]          m_value_re_in,
  output logic [15:0]          m_value_re_out,
  output logic [3:0]           ep_bits,
  output logic [AW-1:0]        bits_avail,
  output logic [CNT_WIDTH-1:0] bits_consumed,
  output logic                 underrun
);

  logic [BUF_WIDTH-1:0] bit_buf;
  logic [AW-1:0]        cnt;
  logic                 eos_seen;
  logic [2:0]           need;
  logic [2:0]           need_eff;
  logic                 accept;
  logic                 consume;
  logic [7:0]           head;
  logic [BUF_WIDTH-1:0] buf_next;
  logic [AW-1:0]        cnt_next;

  // Handshakes and zero-latency decoder-facing outputs.
  always_comb begin
    need           = bypass ? ({1'b0, n_bin} + 3'd1) : num_bits;
    byte_ready     = reset && !eos_seen && (cnt <= AW'(BUF_WIDTH - BYTE_BITS));
    cons_ready     = reset && ((cnt >= AW'(need)) || eos_seen);
    accept         = byte_valid && byte_ready;
    consume        = cons_valid && cons_ready;
    need_eff       = consume ? need : 3'd0;
    head           = bit_buf[BUF_WIDTH-1 -: BYTE_BITS];
    m_value_re_out = m_value_re_in | ({8'h00, head} >> (4'd8 - {1'b0, num_bits}));
    ep_bits        = bit_buf[BUF_WIDTH-1 -: MAX_EP_BINS];
    bits_avail     = cnt;
  end

  cabac_bit_shifter #(
    .BUF_WIDTH (BUF_WIDTH),
    .AW        (AW)
  ) u_shifter (
    .bit_buf  (bit_buf),
    .cnt      (cnt),
    .need     (need_eff),
    .byte_in  (byte_in),
    .accept   (accept),
    .buf_next (buf_next),
    .cnt_next (cnt_next)
  );

  // Buffer, stream-end flag, statistics and sticky underrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_buf       <= '0;
      cnt           <= '0;
      eos_seen      <= 1'b0;
      bits_consumed <= '0;
      underrun      <= 1'b0;
    end else begin
      bit_buf  <= buf_next;
      cnt      <= cnt_next;
      eos_seen <= eos_seen | eos;
      if (consume) begin
        bits_consumed <= bits_consumed + CNT_WIDTH'(need);
        if (cnt < AW'(need)) underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cabac_bit_feeder.sv
// Directed self-checking bench for cabac_bit_feeder.
module tb_cabac_bit_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        eos;
  logic        cons_valid;
  logic        cons_ready;
  logic        bypass;
  logic [2:0]  num_bits;
  logic [1:0]  n_bin;
  logic [15:0] m_value_re_in;
  logic [15:0] m_value_re_out;
  logic [3:0]  ep_bits;
  logic [5:0]  bits_avail;
  logic [31:0] bits_consumed;
  logic        underrun;

  int n_pass  = 0;
  int n_total = 0;

  cabac_bit_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .eos            (eos),
    .cons_valid     (cons_valid),
    .cons_ready     (cons_ready),
    .bypass         (bypass),
    .num_bits       (num_bits),
    .n_bin          (n_bin),
    .m_value_re_in  (m_value_re_in),
    .m_value_re_out (m_value_re_out),
    .ep_bits        (ep_bits),
    .bits_avail     (bits_avail),
    .bits_consumed  (bits_consumed),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    byte_in = 8'h00; byte_valid = 1'b0; eos = 1'b0; cons_valid = 1'b0;
    bypass = 1'b0; num_bits = 3'd0; n_bin = 2'd0; m_value_re_in = 16'h0000;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    byte_in = b; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    byte_valid = 1'b1; cons_valid = 1'b1;
    tick();
    n_total++; if (byte_ready !== 1'b0) $display("FAIL rst_byte_ready: got %b want 0", byte_ready); else n_pass++;
    n_total++; if (cons_ready !== 1'b0) $display("FAIL rst_cons_ready: got %b want 0", cons_ready); else n_pass++;
    idle_inputs();
    reset = 1'b1;
    #1;
    n_total++; if (bits_avail !== 6'd0) $display("FAIL rst_avail: got %0d want 0", bits_avail); else n_pass++;
    n_total++; if (bits_consumed !== 32'd0) $display("FAIL rst_consumed: got %0d want 0", bits_consumed); else n_pass++;
    n_total++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", underrun); else n_pass++;
    n_total++; if (byte_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", byte_ready); else n_pass++;
  endtask

  task automatic test_regular;
    do_reset();
    push(8'hA5);
    push(8'h3C);
    n_total++; if (bits_avail !== 6'd16) $display("FAIL reg_avail16: got %0d want 16", bits_avail); else n_pass++;
    n_total++; if (ep_bits !== 4'b1010) $display("FAIL reg_ep0: got %b want 1010", ep_bits); else n_pass++;
    n_total++; if (byte_ready !== 1'b1) $display("FAIL reg_byte_ready: got %b want 1", byte_ready); else n_pass++;
    cons_valid = 1'b1; bypass = 1'b0; num_bits = 3'd3; m_value_re_in = 16'h8000;
    #1;
    n_total++; if (cons_ready !== 1'b1) $display("FAIL reg_cons_ready: got %b want 1", cons_ready); else n_pass++;
    n_total++; if (m_value_re_out !== 16'h8005) $display("FAIL reg_mvalue: got %h want 8005", m_value_re_out); else n_pass++;
    tick();
    cons_valid = 1'b0;
    n_total++; if (bits_avail !== 6'd13) $display("FAIL reg_avail13: got %0d want 13", bits_avail); else n_pass++;
    n_total++; if (ep_bits !== 4'b0010) $display("FAIL reg_ep1: got %b want 0010", ep_bits); else n_pass++;
    n_total++; if (bits_consumed !== 32'd3) $display("FAIL reg_consumed: got %0d want 3", bits_consumed); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_nib [5];
    exp_nib[0] = 4'hC; exp_nib[1] = 4'h5; exp_nib[2] = 4'hA; exp_nib[3] = 4'hF; exp_nib[4] = 4'h0;
    do_reset();
    push(8'h3C);
    push(8'h5A);
    n_total++; if (ep_bits !== 4'b0011) $display("FAIL b2b_ep_before: got %b want 0011", ep_bits); else n_pass++;
    cons_valid = 1'b1; bypass = 1'b1; n_bin = 2'd3;
    byte_in = 8'hF0; byte_valid = 1'b1;
    #1;
    n_total++; if ({cons_ready, byte_ready} !== 2'b11) $display("FAIL b2b_both_ready: got %b want 11", {cons_ready, byte_ready}); else n_pass++;
    tick();
    byte_valid = 1'b0; cons_valid = 1'b0;
    n_total++; if (bits_avail !== 6'd20) $display("FAIL b2b_avail: got %0d want 20", bits_avail); else n_pass++;
    n_total++; if (bits_consumed !== 32'd4) $display("FAIL b2b_consumed: got %0d want 4", bits_consumed); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (ep_bits !== exp_nib[i]) $display("FAIL b2b_stream[%0d]: got %h want %h", i, ep_bits, exp_nib[i]); else n_pass++;
      cons_valid = 1'b1; bypass = 1'b1; n_bin = 2'd3;
      tick();
      cons_valid = 1'b0;
    end
    n_total++; if (bits_avail !== 6'd0) $display("FAIL b2b_drained: got %0d want 0", bits_avail); else n_pass++;
    n_total++; if (underrun !== 1'b0) $display("FAIL b2b_underrun: got %b want 0", underrun); else n_pass++;
  endtask

  task automatic test_fill;
    do_reset();
    byte_valid = 1'b1;
    byte_in = 8'h11; tick();
    byte_in = 8'h22; tick();
    byte_in = 8'h33; tick();
    n_total++; if (byte_ready !== 1'b1) $display("FAIL fill_ready24: got %b want 1", byte_ready); else n_pass++;
    byte_in = 8'h44; tick();
    byte_in = 8'h55;
    n_total++; if (bits_avail !== 6'd32) $display("FAIL fill_avail32: got %0d want 32", bits_avail); else n_pass++;
    n_total++; if (byte_ready !== 1'b0) $display("FAIL fill_ready32: got %b want 0", byte_ready); else n_pass++;
    cons_valid = 1'b1; bypass = 1'b0; num_bits = 3'd7;
    tick();
    cons_valid = 1'b0;
    n_total++; if (bits_avail !== 6'd25) $display("FAIL fill_avail25: got %0d want 25", bits_avail); else n_pass++;
    n_total++; if (byte_ready !== 1'b0) $display("FAIL fill_ready25: got %b want 0", byte_ready); else n_pass++;
    tick();
    n_total++; if (bits_avail !== 6'd25) $display("FAIL fill_hold25: got %0d want 25", bits_avail); else n_pass++;
    cons_valid = 1'b1; num_bits = 3'd1;
    tick();
    cons_valid = 1'b0;
    n_total++; if (bits_avail !== 6'd24) $display("FAIL fill_avail24: got %0d want 24", bits_avail); else n_pass++;
    n_total++; if (byte_ready !== 1'b1) $display("FAIL fill_reassert: got %b want 1", byte_ready); else n_pass++;
    tick();
    byte_valid = 1'b0;
    n_total++; if (bits_avail !== 6'd32) $display("FAIL fill_refill: got %0d want 32", bits_avail); else n_pass++;
    num_bits = 3'd7; m_value_re_in = 16'h0000;
    #1;
    n_total++; if (m_value_re_out !== 16'h0011) $display("FAIL fill_head: got %h want 0011", m_value_re_out); else n_pass++;
    n_total++; if (bits_consumed !== 32'd8) $display("FAIL fill_consumed: got %0d want 8", bits_consumed); else n_pass++;
  endtask

  task automatic test_eos_underrun;
    do_reset();
    push(8'h03);
    cons_valid = 1'b1; bypass = 1'b0; num_bits = 3'd6;
    tick();
    cons_valid = 1'b0;
    n_total++; if (bits_avail !== 6'd2) $display("FAIL eos_avail2: got %0d want 2", bits_avail); else n_pass++;
    eos = 1'b1;
    tick();
    eos = 1'b0;
    n_total++; if (byte_ready !== 1'b0) $display("FAIL eos_byte_ready: got %b want 0", byte_ready); else n_pass++;
    cons_valid = 1'b1; bypass = 1'b1; n_bin = 2'd3;
    #1;
    n_total++; if (cons_ready !== 1'b1) $display("FAIL eos_cons_ready: got %b want 1", cons_ready); else n_pass++;
    n_total++; if (ep_bits !== 4'b1100) $display("FAIL eos_ep_pad: got %b want 1100", ep_bits); else n_pass++;
    tick();
    cons_valid = 1'b0;
    n_total++; if (underrun !== 1'b1) $display("FAIL eos_underrun: got %b want 1", underrun); else n_pass++;
    n_total++; if (bits_avail !== 6'd0) $display("FAIL eos_avail0: got %0d want 0", bits_avail); else n_pass++;
    n_total++; if (bits_consumed !== 32'd10) $display("FAIL eos_consumed: got %0d want 10", bits_consumed); else n_pass++;
    tick();
    n_total++; if (underrun !== 1'b1) $display("FAIL eos_sticky: got %b want 1", underrun); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (underrun !== 1'b0) $display("FAIL eos_rst_underrun: got %b want 0", underrun); else n_pass++;
    n_total++; if (bits_consumed !== 32'd0) $display("FAIL eos_rst_consumed: got %0d want 0", bits_consumed); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_stall;
    do_reset();
    cons_valid = 1'b1; bypass = 1'b0; num_bits = 3'd5; m_value_re_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (cons_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", i, cons_ready); else n_pass++;
      tick();
      n_total++; if (bits_consumed !== 32'd0) $display("FAIL stall_consumed[%0d]: got %0d want 0", i, bits_consumed); else n_pass++;
    end
    byte_in = 8'hE8; byte_valid = 1'b1;
    #1;
    n_total++; if (cons_ready !== 1'b0) $display("FAIL stall_arrive_ready: got %b want 0", cons_ready); else n_pass++;
    tick();
    byte_valid = 1'b0;
    #1;
    n_total++; if (cons_ready !== 1'b1) $display("FAIL stall_release: got %b want 1", cons_ready); else n_pass++;
    n_total++; if (m_value_re_out !== 16'h001D) $display("FAIL stall_mvalue: got %h want 001d", m_value_re_out); else n_pass++;
    tick();
    cons_valid = 1'b0;
    n_total++; if (bits_consumed !== 32'd5) $display("FAIL stall_consumed_after: got %0d want 5", bits_consumed); else n_pass++;
    n_total++; if (bits_avail !== 6'd3) $display("FAIL stall_avail: got %0d want 3", bits_avail); else n_pass++;
  endtask

  task automatic test_need_zero;
    do_reset();
    cons_valid = 1'b1; bypass = 1'b0; num_bits = 3'd0; m_value_re_in = 16'h1234;
    #1;
    n_total++; if (cons_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", cons_ready); else n_pass++;
    n_total++; if (m_value_re_out !== 16'h1234) $display("FAIL zero_passthru: got %h want 1234", m_value_re_out); else n_pass++;
    tick();
    cons_valid = 1'b0;
    n_total++; if (bits_consumed !== 32'd0) $display("FAIL zero_consumed: got %0d want 0", bits_consumed); else n_pass++;
    n_total++; if ({underrun, bits_avail} !== 7'd0) $display("FAIL zero_state: got %b want 0", {underrun, bits_avail}); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    test_reset();
    test_regular();
    test_back_to_back();
    test_fill();
    test_eos_underrun();
    test_stall();
    test_need_zero();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
